// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared types and widths for the UART debug initiator.
package uart_dbg_pkg;

    localparam int DBG_WORD_W = 32;
    localparam int DBG_CMD_W  = 4;

    // Send/echo pairs are consecutive so "advance" is state + 1.
    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_CMD,
        S_ECHO_CMD,
        S_SEND_ADDR,
        S_ECHO_ADDR,
        S_SEND_DATA,
        S_ECHO_DATA,
        S_WAIT_REPLY,
        S_DONE,
        S_ABORT
    } dbg_init_state_t;

    typedef enum logic [1:0] {
        RSP_OK       = 2'b00,
        RSP_MISMATCH = 2'b01,
        RSP_TIMEOUT  = 2'b10
    } dbg_rsp_code_t;

    function automatic logic [DBG_WORD_W-1:0] cmd_word(input logic [DBG_CMD_W-1:0] c);
        return {{(DBG_WORD_W - DBG_CMD_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/uart_rx_word.sv
// uart_rx_word: assembles four 8N1 bytes (LSB byte first) into a word; pulses ready per word.
module uart_rx_word #(
    parameter int CLK_RATE = 50,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        srx,
    output logic [31:0] data,
    output logic        ready
);
    localparam int DIV = CLK_RATE * 1_000_000 / BAUD;
    localparam int CW  = $clog2(DIV + 1);

    logic [1:0]    sync_q;
    logic          act_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [7:0]    sh_q;
    logic [1:0]    byte_q;
    logic [31:0]   word_q;
    logic          ready_q;
    logic          rx;

    assign rx = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], srx};
            ready_q <= 1'b0;
            if (!act_q) begin
                if (!rx) begin
                    act_q <= 1'b1;
                    cnt_q <= CW'(DIV / 2);
                    bit_q <= '0;
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end else begin
                cnt_q <= CW'(DIV - 1);
                bit_q <= bit_q + 4'd1;
                // A start bit that is high again at mid-bit was a glitch.
                if (bit_q == 4'd0) act_q <= !rx;
                else if (bit_q != 4'd9) sh_q <= {rx, sh_q[7:1]};
                else begin
                    act_q <= 1'b0;
                    if (rx) begin
                        word_q  <= {sh_q, word_q[31:8]};
                        byte_q  <= byte_q + 2'd1;
                        ready_q <= byte_q == 2'd3;
                    end
                end
            end
        end
    end

    assign data  = word_q;
    assign ready = ready_q;

endmodule

// File: rtl/uart_tx_word.sv
// uart_tx_word: sends a 32-bit word as four 8N1 bytes, least significant byte first.
module uart_tx_word #(
    parameter int CLK_RATE = 50,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data,
    output logic        stx,
    output logic        idle
);
    localparam int DIV = CLK_RATE * 1_000_000 / BAUD;
    localparam int CW  = $clog2(DIV + 1);

    logic [39:0]   sh_q;
    logic [5:0]    bits_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '1;
            bits_q <= '0;
            cnt_q  <= '0;
        end else if (bits_q == '0) begin
            if (start) begin
                sh_q   <= {1'b1, data[31:24], 1'b0, 1'b1, data[23:16], 1'b0,
                           1'b1, data[15:8], 1'b0, 1'b1, data[7:0], 1'b0};
                bits_q <= 6'd40;
                cnt_q  <= CW'(DIV - 1);
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end else begin
            sh_q   <= {1'b1, sh_q[39:1]};
            bits_q <= bits_q - 6'd1;
            cnt_q  <= CW'(DIV - 1);
        end
    end

    assign idle = bits_q == '0;
    assign stx  = idle | sh_q[0];

endmodule

// File: rtl/uart_dbg_initiator.sv
// uart_dbg_initiator: runs one cmd/addr/data transaction with echo checks per request
// and returns the target's reply word, aborting on echo mismatch or timeout.
module uart_dbg_initiator
    import uart_dbg_pkg::*;
#(
    parameter int CLK_RATE       = 50,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  srx,
    output logic                  stx,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DBG_CMD_W-1:0]  req_cmd,
    input  logic [DBG_WORD_W-1:0] req_addr,
    input  logic [DBG_WORD_W-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DBG_WORD_W-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [1:0]            rsp_code,
    output logic                  busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    dbg_init_state_t       state_q;
    dbg_rsp_code_t         code_q;
    logic [DBG_CMD_W-1:0]  cmd_q;
    logic [DBG_WORD_W-1:0] addr_q, data_q, rsp_data_q;
    logic [TW-1:0]         tmo_q;
    logic                  start_q;
    logic                  rst, tx_start, tx_idle, rx_ready, timed_out;
    logic [DBG_WORD_W-1:0] cur_word, rx_word;

    assign rst = !rst_n;

    // The same word is transmitted in SEND_x and expected back in ECHO_x.
    always_comb begin
        cur_word  = state_q inside {S_SEND_CMD, S_ECHO_CMD}   ? cmd_word(cmd_q) :
                    state_q inside {S_SEND_ADDR, S_ECHO_ADDR} ? addr_q : data_q;
        tx_start  = state_q inside {S_SEND_CMD, S_SEND_ADDR, S_SEND_DATA} && tx_idle && !start_q;
        timed_out = tmo_q <= TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            code_q     <= RSP_OK;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            tmo_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            start_q <= tx_start;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    cmd_q   <= req_cmd;
                    addr_q  <= req_addr;
                    data_q  <= req_data;
                    code_q  <= RSP_OK;
                    state_q <= S_SEND_CMD;
                end
                S_SEND_CMD, S_SEND_ADDR, S_SEND_DATA: if (tx_start) begin
                    tmo_q   <= TW'(TIMEOUT_CYCLES);
                    state_q <= dbg_init_state_t'(state_q + 4'd1);
                end
                S_ECHO_CMD, S_ECHO_ADDR, S_ECHO_DATA, S_WAIT_REPLY: begin
                    tmo_q <= tmo_q - TW'(1);
                    // A ready arriving on the last timeout cycle still counts as received.
                    if (rx_ready && state_q == S_WAIT_REPLY) begin
                        rsp_data_q <= rx_word;
                        state_q    <= S_DONE;
                    end else if (rx_ready && rx_word == cur_word) begin
                        tmo_q   <= TW'(TIMEOUT_CYCLES);
                        state_q <= dbg_init_state_t'(state_q + 4'd1);
                    end else if (rx_ready || timed_out) begin
                        code_q     <= rx_ready ? RSP_MISMATCH : RSP_TIMEOUT;
                        rsp_data_q <= '0;
                        state_q    <= S_ABORT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = state_q == S_IDLE;
    assign busy      = !req_ready;
    assign rsp_valid = state_q inside {S_DONE, S_ABORT};
    assign rsp_err   = state_q == S_ABORT;
    assign rsp_code  = code_q;
    assign rsp_data  = rsp_data_q;

    uart_tx_word #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (cur_word),
        .stx  (stx),
        .idle (tx_idle)
    );

    uart_rx_word #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) u_rx (
        .clk  (clk),
        .rst  (rst),
        .srx  (srx),
        .data (rx_word),
        .ready(rx_ready)
    );

endmodule

// File: tb/tb_uart_dbg_initiator.sv
// tb_uart_dbg_initiator: directed vectors against a behavioural serial target model.
module tb_uart_dbg_initiator;
    import uart_dbg_pkg::*;

    localparam int DIV = 10;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr, data, reply;
        int          mode;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, srx = 1'b1, req_valid = 1'b0;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_addr = '0, req_data = '0;
    logic        stx, req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_code;
    int          n_cmp = 0, n_bad = 0, pulses = 0;
    vec_t        vecs[6];

    uart_dbg_initiator #(.CLK_RATE(50), .BAUD(5_000_000), .TIMEOUT_CYCLES(1000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .srx      (srx),
        .stx      (stx),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd  (req_cmd),
        .req_addr (req_addr),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .rsp_code (rsp_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rsp_valid) pulses++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic ser_rx(output logic [31:0] w);
        int n;
        w = 'x;
        for (int b = 0; b < 4; b++) begin
            n = 0;
            while (stx !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
            if (n >= 5000) begin fail("tgt_rx_start"); return; end
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                w[8*b+i] = stx;
            end
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic ser_tx(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            srx = 1'b0;
            repeat (DIV) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                srx = w[8*b+i];
                repeat (DIV) @(negedge clk);
            end
            srx = 1'b1;
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic expect_quiet(input string name);
        int lows;
        lows = 0;
        repeat (600) begin @(negedge clk); if (!stx) lows++; end
        check(name, 32'(lows), 32'd0);
    endtask

    // mode: 0 ok, 1 bad cmd echo, 2 bad addr echo, 3 bad data echo, 4 no reply
    task automatic target(input int mode, input logic [3:0] c, input logic [31:0] a, d, rep);
        logic [31:0] w;
        ser_rx(w); check("tgt_cmd", w, cmd_word(c));
        ser_tx(mode == 1 ? w ^ 32'h1 : w);
        if (mode == 1) begin expect_quiet("no_addr_after_bad_cmd"); return; end
        ser_rx(w); check("tgt_addr", w, a);
        ser_tx(mode == 2 ? w ^ 32'h1 : w);
        if (mode == 2) begin expect_quiet("no_data_after_bad_addr"); return; end
        ser_rx(w); check("tgt_data", w, d);
        ser_tx(mode == 3 ? w ^ 32'h1 : w);
        if (mode == 3) begin expect_quiet("no_tx_after_bad_data"); return; end
        if (mode != 4) ser_tx(rep);
    endtask

    task automatic request(input logic [3:0] c, input logic [31:0] a, d,
                           output logic [31:0] rd, output logic e, output logic [1:0] code);
        int n;
        req_cmd = c; req_addr = a; req_data = d; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("ready_after_accept", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 8000) begin @(negedge clk); n++; end
        if (!rsp_valid) fail("rsp_valid_wait");
        rd = rsp_data; e = rsp_err; code = rsp_code;
        check("ready_in_rsp_cycle", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] rd;
        logic        e;
        logic [1:0]  code;
        int          p0;
        p0 = pulses;
        fork
            target(v.mode, v.cmd, v.addr, v.data, v.reply);
            request(v.cmd, v.addr, v.data, rd, e, code);
        join
        check("rsp_data", rd, v.exp_data);
        check("rsp_err", 32'(e), 32'(v.exp_err));
        check("rsp_code", 32'(code), 32'(v.exp_code));
        check("rsp_pulses", 32'(pulses - p0), 32'd1);
    endtask

    task automatic timeout_seq();
        logic [31:0] rd;
        logic        e;
        logic [1:0]  code;
        fork
            target(4, 4'h9, 32'h0000_0010, 32'h0000_0020, 32'h0);
            request(4'h9, 32'h0000_0010, 32'h0000_0020, rd, e, code);
            begin
                int n, t;
                n = 0;
                while (dut.state_q != S_WAIT_REPLY && n < 5000) begin @(negedge clk); n++; end
                t = 0;
                while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
                check("timeout_cycles", 32'(t), 32'd1000);
            end
        join
        check("timeout_code", 32'(code), 32'd2);
        check("timeout_err", 32'(e), 32'd1);
        check("timeout_data", rd, 32'd0);
    endtask

    task automatic reset_mid();
        logic [31:0] w;
        int          n, p0, lows;
        p0 = pulses;
        req_cmd = 4'h4; req_addr = 32'h0000_2000; req_data = 32'h3; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        ser_rx(w); check("rst_cmd", w, cmd_word(4'h4));
        ser_tx(w);
        n = 0;
        while (stx !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) fail("rst_addr_start");
        repeat (100) @(negedge clk);
        check("rst_pre_stx_low", 32'(stx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_stx", 32'(stx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        lows = 0;
        repeat (200) begin @(negedge clk); if (!stx) lows++; end
        check("rst_stx_quiet", 32'(lows), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_rsp", 32'(pulses - p0), 32'd0);
        run_vec(vecs[0]);
    endtask

    task automatic back_to_back();
        fork
            begin
                target(0, 4'h1, 32'h0000_0100, 32'h0000_0200, 32'h1111_2222);
                target(0, 4'h5, 32'h0000_0500, 32'h0000_0600, 32'h3333_4444);
            end
            begin
                int n, rr;
                req_cmd = 4'h1; req_addr = 32'h0000_0100; req_data = 32'h0000_0200; req_valid = 1'b1;
                @(negedge clk);
                check("b2b_busy1", 32'(busy), 32'd1);
                req_cmd = 4'h5; req_addr = 32'h0000_0500; req_data = 32'h0000_0600;
                rr = 0; n = 0;
                while (!rsp_valid && n < 8000) begin
                    if (req_ready) rr++;
                    @(negedge clk);
                    n++;
                end
                check("b2b_ready_low", 32'(rr), 32'd0);
                check("b2b_rsp1", rsp_data, 32'h1111_2222);
                check("b2b_ready_rsp", 32'(req_ready), 32'd0);
                @(negedge clk);
                check("b2b_accept_cycle", 32'(req_ready), 32'd1);
                @(negedge clk);
                check("b2b_busy2", 32'(busy), 32'd1);
                req_valid = 1'b0;
                n = 0;
                while (!rsp_valid && n < 8000) begin @(negedge clk); n++; end
                check("b2b_rsp2", rsp_data, 32'h3333_4444);
                check("b2b_err2", 32'(rsp_err), 32'd0);
                @(negedge clk);
            end
        join
    endtask

    task automatic spurious();
        int p0;
        p0 = pulses;
        ser_tx(32'hDEAD_BEEF);
        repeat (20) @(negedge clk);
        check("spur_ready", 32'(req_ready), 32'd1);
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_no_rsp", 32'(pulses - p0), 32'd0);
        run_vec(vecs[0]);
    endtask

    initial begin
        vecs[0] = '{4'h2, 32'h0000_1000, 32'h1234_5678, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 2'b00};
        vecs[1] = '{4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 32'h0000_0001, 1'b0, 2'b00};
        vecs[2] = '{4'h0, 32'h8000_0001, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b0, 2'b00};
        vecs[3] = '{4'h2, 32'h0000_1000, 32'h1234_5678, 32'hCAFE_F00D, 2, 32'h0000_0000, 1'b1, 2'b01};
        vecs[4] = '{4'h3, 32'h0000_0004, 32'h0000_0005, 32'h0000_0000, 1, 32'h0000_0000, 1'b1, 2'b01};
        vecs[5] = '{4'h7, 32'hDEAD_0000, 32'h0000_BEEF, 32'h0000_1111, 3, 32'h0000_0000, 1'b1, 2'b01};
        repeat (3) @(negedge clk);
        check("reset_stx", 32'(stx), 32'd1);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_code", 32'(rsp_code), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        timeout_seq();
        reset_mid();
        back_to_back();
        spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
